axi_write_responder: RTL

//  AXI4 write-channel responder (memory side) for the data cache's write initiator.

---
 rtl/axi_write_responder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/axi_write_responder.sv
// AXI4 write-channel responder backed by a word-addressed 64-bit store.
// Accepts one AW, then awlen+1 W beats. It writes the strobed bytes of each beat,
// then returns a single B response. SLVERR is returned for a misaligned start
// address, for beats that fall outside the store, or for a wlast that does not
// line up with the final beat.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   s_axi_aw{addr,len,valid,ready}     write address channel (INCR only)
//   s_axi_w{data,strb,last,valid,ready} write data channel
//   s_axi_b{resp,valid,ready}          write response channel
//   dbg_addr / dbg_data                combinational read of the store (0 out of range)
module axi_write_responder #(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter logic [63:0] BASE_ADDR   = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [63:0] dbg_addr,
    output logic [63:0] dbg_data
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned IW = 61;

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic [IW-1:0] aw_idx;
    logic [IW-1:0] dbg_idx;
    logic [7:0]    len;
    logic [7:0]    cnt;
    logic          err;
    logic          aw_hs;
    logic          w_hs;
    logic          b_hs;
    logic          in_range;
    logic          last_beat;
    logic          beat_err;

    logic [63:0]   mem [DEPTH_WORDS];

    // Handshake outputs decoded from the state; all forced low while reset is high
    assign s_axi_awready = (state == IDLE) && !reset;
    assign s_axi_wready  = (state == DATA) && !reset;
    assign s_axi_bvalid  = (state == RESP) && !reset;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid  && s_axi_wready;
    assign b_hs  = s_axi_bvalid  && s_axi_bready;

    // Word index of the burst start; low address bits are ignored (flagged as error)
    assign aw_idx    = IW'((s_axi_awaddr - BASE_ADDR) >> 3);
    assign in_range  = idx < IW'(DEPTH_WORDS);
    assign last_beat = (cnt == len);
    // wlast must be set on the final beat and only there
    assign beat_err  = !in_range || (last_beat != s_axi_wlast);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (aw_hs) state_nxt = DATA;
            DATA:    if (w_hs && last_beat) state_nxt = RESP;
            RESP:    if (b_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Burst bookkeeping: beat counter, sticky error and response code
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= 8'd0;
            err         <= 1'b0;
            s_axi_bresp <= 2'b00;
        end else begin
            if (aw_hs) begin
                cnt <= 8'd0;
                err <= (s_axi_awaddr[2:0] != 3'd0);
            end
            if (w_hs) begin
                cnt <= cnt + 8'd1;
                if (beat_err) err <= 1'b1;
                if (last_beat) s_axi_bresp <= (err || beat_err) ? 2'b10 : 2'b00;
            end
            if (b_hs) err <= 1'b0;
        end
    end

    // Address and length of the current burst; no reset needed
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            idx <= aw_idx;
            len <= s_axi_awlen;
        end else if (w_hs) begin
            idx <= idx + IW'(1);
        end
    end

    // Byte-enabled store write; out-of-range beats are dropped
    always_ff @(posedge clk) begin
        if (w_hs && in_range) begin
            for (int b = 0; b < 8; b++) begin
                if (s_axi_wstrb[b]) mem[idx[AW-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    // Debug read port using the same byte-address mapping
    assign dbg_idx  = IW'((dbg_addr - BASE_ADDR) >> 3);
    assign dbg_data = (dbg_idx < IW'(DEPTH_WORDS)) ? mem[dbg_idx[AW-1:0]] : 64'd0;

endmodule
